// File: rtl/spi_pkg_hdl.sv
// Shared definitions for the SPI master: FSM state encoding and default widths.
package spi_pkg_hdl;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: latches N on load, counts 0..N while enabled, ticks on N.
module spi_clk_div
  import spi_pkg_hdl::*;
#(
  parameter int DIV_W = SPI_DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] n_i,
  input  logic             en_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] n_q;
  logic [DIV_W-1:0] n_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // The count never passes n_q, so N = all-ones cannot wrap.
  assign tick_o = en_i & (cnt_q == n_q);

  always_comb begin
    n_d   = n_q;
    cnt_d = cnt_q;
    if (load_i) begin
      n_d   = n_i;
      cnt_d = '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q   <= '0;
      cnt_q <= '0;
    end else begin
      n_q   <= n_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master, MSB first, one word per start. Define SPI_MASTER_IRQ_EN to
// build the sticky completion interrupt; otherwise irq_o is tied low.
module spi_master_core
  import spi_pkg_hdl::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int DIV_W  = SPI_DIV_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              ie_i,
  input  logic              irq_clr_i,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              ss_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              irq_o
);

  localparam int              BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_s;
  logic              run_s;
  logic              tick_s;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .load_i (load_s),
    .n_i    (clk_div_i),
    .en_i   (run_s),
    .tick_o (tick_s)
  );

  // One shift register serves both directions: MSB drives mosi, miso enters at the LSB.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    run_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_s  = 1'b1;
          shift_d = tx_data_i;
          bit_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = tx_data_i[DATA_W-1];
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        run_s = 1'b1;
        if (tick_s) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[DATA_W-2:0], miso_i};
          state_d = ST_HIGH;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        run_s = 1'b1;
        if (tick_s) begin
          sclk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            rx_d    = shift_q;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            mosi_d  = shift_q[DATA_W-1];
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_LOW;
          end
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_DONE: begin
        mosi_d  = 1'b0;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign ss_n_o    = ss_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_q;

`ifdef SPI_MASTER_IRQ_EN
  logic irq_q, irq_d;

  // Setting wins over clearing, and a clear landing in the done cycle itself is dropped.
  always_comb begin
    irq_d = irq_q;
    if (done_d && ie_i) begin
      irq_d = 1'b1;
    end else if (irq_clr_i && !done_q) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_s;
  assign unused_irq_s = ie_i ^ irq_clr_i;
  assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: cycle-level behavioural model plus directed literal checks.
module tb_spi_master_core;

  localparam int W  = 8;
  localparam int DW = 8;
`ifdef SPI_MASTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst   = 1'b1;
  logic          start_i   = 1'b0;
  logic [W-1:0]  tx_data_i = '0;
  logic [DW-1:0] clk_div_i = '0;
  logic          ie_i      = 1'b0;
  logic          irq_clr_i = 1'b0;
  logic          sclk_o, mosi_o, miso_i, ss_n_o, busy_o, done_o, irq_o;
  logic [W-1:0]  rx_data_o;

  // stimulus knobs
  logic          miso_pat = 1'b0;
  logic          loop_en  = 1'b0;
  logic [W-1:0]  pat_word = '0;

  int checks = 0;
  int errors = 0;

  // model: m_t = cycles since the accepted start (0 = idle)
  int            m_t   = 0;
  int            m_h   = 1;
  logic [W-1:0]  m_tx  = '0;
  logic [W-1:0]  m_pat = '0;
  logic [W-1:0]  m_rx  = '0;
  logic          m_loop = 1'b0;
  logic          m_irq  = 1'b0;

  int   busy_cnt  = 0;
  int   rise_cnt  = 0;
  int   done_cnt  = 0;
  logic sclk_prev = 1'b0;

  assign miso_i = m_loop ? mosi_o : miso_pat;

  always #5 sys_clk = ~sys_clk;

  spi_master_core #(.DATA_W(W), .DIV_W(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start_i   (start_i),
    .tx_data_i (tx_data_i),
    .clk_div_i (clk_div_i),
    .ie_i      (ie_i),
    .irq_clr_i (irq_clr_i),
    .sclk_o    (sclk_o),
    .mosi_o    (mosi_o),
    .miso_i    (miso_i),
    .ss_n_o    (ss_n_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rx_data_o (rx_data_o),
    .irq_o     (irq_o)
  );

  function automatic int xfer_len(input int h);
    return 2 * W * h + 1;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_t   <= 0;
      m_rx  <= '0;
      m_irq <= 1'b0;
    end else begin
      if (IRQ_ON && m_t == xfer_len(m_h) - 1 && ie_i) m_irq <= 1'b1;
      else if (irq_clr_i && m_t != xfer_len(m_h)) m_irq <= 1'b0;
      if (m_t == 0) begin
        if (start_i) begin
          m_t    <= 1;
          m_tx   <= tx_data_i;
          m_h    <= int'(clk_div_i) + 1;
          m_pat  <= pat_word;
          m_loop <= loop_en;
        end
      end else if (m_t == xfer_len(m_h)) begin
        m_t <= 0;
      end else begin
        m_t <= m_t + 1;
        if (m_t == xfer_len(m_h) - 1) m_rx <= m_loop ? m_tx : m_pat;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int   ph;
    logic e_sclk, e_mosi, e_busy, e_ss, e_done;
    e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_ss = 1'b1; e_done = 1'b0;
    if (m_t == 0) begin
      e_busy = 1'b0;
    end else if (m_t < xfer_len(m_h)) begin
      ph     = (m_t - 1) / m_h;
      e_sclk = ((ph % 2) == 1);
      e_mosi = m_tx[W-1-(ph/2)];
      e_busy = 1'b1;
      e_ss   = 1'b0;
    end else begin
      e_mosi = m_tx[0];
      e_busy = 1'b1;
      e_ss   = 1'b0;
      e_done = 1'b1;
    end
    chk("sclk", sclk_o, e_sclk);
    chk("mosi", mosi_o, e_mosi);
    chk("busy", busy_o, e_busy);
    chk("ss_n", ss_n_o, e_ss);
    chk("done", done_o, e_done);
    chk("rx_data", rx_data_o, m_rx);
    chk("irq", irq_o, m_irq);
  endtask

  // one clock: compare at the falling edge, then present this cycle's miso bit
  task automatic cyc();
    @(negedge sys_clk);
    cmp_model();
    if (busy_o) busy_cnt++;
    if (sclk_o && !sclk_prev) rise_cnt++;
    if (done_o) done_cnt++;
    sclk_prev = sclk_o;
    if (m_t >= 1 && m_t < xfer_len(m_h)) miso_pat = m_pat[W-1-((m_t-1)/(2*m_h))];
    else miso_pat = 1'b0;
  endtask

  task automatic start_xfer(input logic [W-1:0] tx, input int n, input logic lp, input logic [W-1:0] pat);
    tx_data_i = tx;
    clk_div_i = DW'(n);
    loop_en   = lp;
    pat_word  = pat;
    start_i   = 1'b1;
    cyc();
    start_i   = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input bit scramble);
    int k;
    k = 0;
    do begin
      if (scramble) begin
        tx_data_i = W'($urandom);
        clk_div_i = DW'($urandom_range(0, 5));
        pat_word  = W'($urandom);
        loop_en   = ($urandom_range(0, 1) == 1);
        start_i   = ($urandom_range(0, 3) == 0);
        irq_clr_i = ($urandom_range(0, 7) == 0);
        ie_i      = ($urandom_range(0, 1) == 1);
      end
      cyc();
      k++;
    end while (busy_o && k < bound);
    start_i   = 1'b0;
    irq_clr_i = 1'b0;
    chk("idle_timeout", busy_o, 1'b0);
  endtask

  initial begin
    int b0, r0, d0;

    repeat (3) cyc();
    chk("rst_ss_n", ss_n_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rx", rx_data_o, 8'h00);
    sys_rst = 1'b0;
    cyc();

    // N=0 loopback 0xA5
    b0 = busy_cnt; r0 = rise_cnt; d0 = done_cnt;
    start_xfer(8'hA5, 0, 1'b1, 8'h00);
    wait_idle(100, 1'b0);
    chk("a5_busy_cycles", busy_cnt - b0, 17);
    chk("a5_sclk_rises", rise_cnt - r0, 8);
    chk("a5_done_pulses", done_cnt - d0, 1);
    chk("a5_rx", rx_data_o, 8'hA5);

    // N=3, slave returns 0xC3
    b0 = busy_cnt; r0 = rise_cnt;
    start_xfer(8'h3C, 3, 1'b0, 8'hC3);
    wait_idle(200, 1'b0);
    chk("c3_busy_cycles", busy_cnt - b0, 65);
    chk("c3_sclk_rises", rise_cnt - r0, 8);
    chk("c3_rx", rx_data_o, 8'hC3);

    // start held high: two back-to-back transfers, then a mid-transfer pulse is ignored
    b0 = busy_cnt; d0 = done_cnt;
    tx_data_i = 8'h5A; clk_div_i = 8'd0; loop_en = 1'b1;
    start_i = 1'b1;
    repeat (22) cyc();
    start_i = 1'b0;
    repeat (3) cyc();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_idle(100, 1'b0);
    chk("b2b_busy_cycles", busy_cnt - b0, 34);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_rx", rx_data_o, 8'h5A);

    // reset after three bits
    d0 = done_cnt;
    start_xfer(8'h6E, 1, 1'b1, 8'h00);
    repeat (12) cyc();
    sys_rst = 1'b1;
    #1;
    chk("arst_sclk", sclk_o, 1'b0);
    chk("arst_mosi", mosi_o, 1'b0);
    chk("arst_ss_n", ss_n_o, 1'b1);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_rx", rx_data_o, 8'h00);
    chk("arst_irq", irq_o, 1'b0);
    repeat (2) cyc();
    sys_rst = 1'b0;
    cyc();
    chk("arst_no_done", done_cnt - d0, 0);
    b0 = busy_cnt;
    start_xfer(8'h81, 0, 1'b1, 8'h00);
    wait_idle(100, 1'b0);
    chk("post_rst_rx", rx_data_o, 8'h81);
    chk("post_rst_busy", busy_cnt - b0, 17);

    // interrupt behaviour
    ie_i = 1'b1;
    start_xfer(8'h33, 0, 1'b1, 8'h00);
    wait_idle(100, 1'b0);
    chk("irq_set", irq_o, IRQ_ON);
    irq_clr_i = 1'b1;
    cyc();
    irq_clr_i = 1'b0;
    chk("irq_cleared", irq_o, 1'b0);
    ie_i = 1'b0;
    start_xfer(8'h44, 0, 1'b1, 8'h00);
    wait_idle(100, 1'b0);
    chk("irq_disabled", irq_o, 1'b0);
    ie_i = 1'b1;
    start_xfer(8'hC6, 0, 1'b1, 8'h00);
    repeat (15) cyc();
    irq_clr_i = 1'b1;
    cyc();
    chk("irq_on_done", irq_o, IRQ_ON);
    cyc();
    irq_clr_i = 1'b0;
    chk("irq_clr_coincident", irq_o, IRQ_ON);
    irq_clr_i = 1'b1;
    cyc();
    irq_clr_i = 1'b0;
    ie_i = 1'b0;

    // widest divider
    b0 = busy_cnt;
    start_xfer(8'h1D, 255, 1'b0, 8'h96);
    wait_idle(5000, 1'b0);
    chk("nmax_busy_cycles", busy_cnt - b0, 4097);
    chk("nmax_rx", rx_data_o, 8'h96);

    // randomized transfers with input noise during the transfer
    for (int i = 0; i < 40; i++) begin
      ie_i = ($urandom_range(0, 1) == 1);
      start_xfer(W'($urandom), int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1), W'($urandom));
      wait_idle(600, 1'b1);
      repeat (int'($urandom_range(0, 2))) cyc();
    end
    ie_i = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per transfer (min 2).
REQ-002 SHALL have parameter DIV_W, default 8, width of the half-period divider.
REQ-003 SHALL have port sys_clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  transfer request, sampled in IDLE only.
REQ-006 SHALL have port tx_data_i  input  DATA_W  word to send, captured on accepted start.
REQ-007 SHALL have port clk_div_i  input  DIV_W  N; SCLK half-period = N+1 sys_clk cycles, captured on accepted start.
REQ-008 SHALL have port ie_i  input  1  interrupt enable.
REQ-009 SHALL have port irq_clr_i  input  1  clears irq_o.
REQ-010 SHALL have port sclk_o  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port mosi_o  output  1  serial data out, MSB first.
REQ-012 SHALL have port miso_i  input  1  serial data in, MSB first.
REQ-013 SHALL have port ss_n_o  output  1  slave select, active-low.
REQ-014 SHALL have ports busy_o  output  1, done_o  output  1 (one-cycle pulse), rx_data_o  output  DATA_W.
REQ-015 SHALL have port irq_o  output  1  sticky completion interrupt.

Function
REQ-016 SHALL implement states IDLE, LOW, HIGH, DONE.
REQ-017 IDLE: start_i=1 SHALL load shift register with tx_data_i, latch N, clear bit and phase counters, go to LOW; next cycle busy_o=1, ss_n_o=0, mosi_o=tx_data_i[DATA_W-1].
REQ-018 LOW: sclk_o=0; after N+1 cycles SHALL drive sclk_o=1, sample miso_i into shift LSB (shift left), go to HIGH.
REQ-019 HIGH: sclk_o=1; after N+1 cycles SHALL drive sclk_o=0; if bit count = DATA_W-1 go to DONE, else present next bit on mosi_o, increment bit count, go to LOW.
REQ-020 DONE: one cycle; SHALL update rx_data_o with received word, pulse done_o, keep busy_o=1 and ss_n_o=0, then IDLE (busy_o=0, ss_n_o=1, mosi_o=0).
REQ-021 busy_o SHALL be high for exactly 2*DATA_W*(N+1)+1 cycles per transfer.
REQ-022 start_i while busy_o=1 SHALL be ignored (no queuing); start_i in DONE cycle SHALL be ignored.
REQ-023 Changes to tx_data_i or clk_div_i mid-transfer SHALL have no effect.
REQ-024 N=0 SHALL give sclk at sys_clk/2; N=2^DIV_W-1 SHALL work without counter overflow.
REQ-025 rx_data_o SHALL hold its value until next DONE.

Reset
REQ-026 sys_rst=1 SHALL asynchronously force IDLE, sclk_o=0, mosi_o=0, ss_n_o=1, busy_o=0, done_o=0, rx_data_o=0, irq_o=0, counters 0.
REQ-027 Reset mid-transfer SHALL abort with no done_o pulse; first start after release SHALL behave as fresh.

Configuration
REQ-028 Macro SPI_MASTER_IRQ_EN defined: irq_o SHALL set on the done_o cycle when ie_i=1, hold until irq_clr_i=1; simultaneous set and clear SHALL leave irq_o=1.
REQ-029 Macro undefined: irq_o SHALL be constant 0; ie_i and irq_clr_i unused; no irq flop.

Structure
REQ-030 State enum typedef and default DATA_W/DIV_W constants SHALL live in the shared spi_pkg_hdl package.
REQ-031 Half-period counting SHALL be a sub-module spi_clk_div (load, count, terminal-count tick output).

Verification
REQ-032 DATA_W=8, N=0, tx=0xA5, miso loopback of mosi -> rx_data_o=0xA5, done_o one pulse, busy_o 17 cycles, 8 sclk rising edges.
REQ-033 N=3, tx=0x3C, miso driven 0xC3 MSB first changing on sclk fall -> rx_data_o=0xC3, sclk high/low 4 cycles each, busy_o 65 cycles.
REQ-034 start_i held high throughout and pulsed mid-transfer -> back-to-back transfers separated by exactly one IDLE cycle, no extra transfer.
REQ-035 sys_rst asserted after 3 bits -> outputs at reset values same cycle, no done_o; next transfer with tx=0x81 returns correct rx.
REQ-036 SPI_MASTER_IRQ_EN defined, ie_i=1 -> irq_o rises on done_o cycle, stays until irq_clr_i; ie_i=0 -> irq_o stays 0; clr coincident with done -> irq_o=1.
